// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// Module   : ex_muldiv_unit
// Brief    : Iterative RV32M multiply/divide unit for the EX stage.
//            Optional macro MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [9:0]       func_i,
  input  logic [WIDTH-1:0] RS1data_i,
  input  logic [WIDTH-1:0] RS2data_i,
  input  logic [4:0]       RDaddr_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       RDaddr_o
);

  localparam int         CW       = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CALC     = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [6:0] M_FUNCT7 = 7'b0000001;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [2:0]         r_f3;
  logic               r_neg;
  logic [4:0]         r_rd;

  logic [2:0]         w_f3;
  logic               w_start, w_is_div, w_sa, w_sb, w_neg_start, w_div0, w_ovf;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_special_res;
  logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_diff;
  logic [2*WIDTH-1:0] w_acc_next, w_prod_s;
  logic [WIDTH-1:0]   w_q, w_r, w_calc_res;
  logic               w_fast;
  logic [WIDTH-1:0]   w_fast_res;

  assign w_f3     = func_i[2:0];
  assign w_start  = valid_i & ~flush_i & (func_i[9:3] == M_FUNCT7);
  assign w_is_div = w_f3[2];

  // A is signed for MULH/MULHSU/DIV/REM; B only for MULH/DIV/REM
  assign w_sa = RS1data_i[WIDTH-1] &
                ((w_f3 == 3'b001) | (w_f3 == 3'b010) | (w_f3 == 3'b100) | (w_f3 == 3'b110));
  assign w_sb = RS2data_i[WIDTH-1] &
                ((w_f3 == 3'b001) | (w_f3 == 3'b100) | (w_f3 == 3'b110));
  assign w_mag_a     = w_sa ? -RS1data_i : RS1data_i;
  assign w_mag_b     = w_sb ? -RS2data_i : RS2data_i;
  assign w_neg_start = (w_is_div & w_f3[1]) ? w_sa : (w_sa ^ w_sb);

  assign w_div0 = w_is_div & (RS2data_i == '0);
  assign w_ovf  = w_is_div & ~w_f3[0] & (RS1data_i == MIN_INT) & (RS2data_i == '1);
  assign w_special_res = w_div0 ? (w_f3[1] ? RS1data_i : '1)
                                : (w_f3[1] ? '0 : MIN_INT);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*WIDTH-1:0] w_fa, w_fb, w_fprod;
  assign w_fa    = {{WIDTH{w_sa}}, RS1data_i};
  assign w_fb    = {{WIDTH{w_sb}}, RS2data_i};
  assign w_fprod = w_fa * w_fb;
  assign w_fast     = ~w_is_div;
  assign w_fast_res = (w_f3 == 3'b000) ? w_fprod[WIDTH-1:0] : w_fprod[2*WIDTH-1:WIDTH];
`else
  assign w_fast     = 1'b0;
  assign w_fast_res = '0;
`endif

  // Multiply: r_acc = {partial high, remaining multiplier}; divide: {remainder, quotient}
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
  assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff    = w_rem_sh - {1'b0, r_opnd};

  always_comb begin
    w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    if (r_f3[2]) begin
      if (w_diff[WIDTH])
        w_acc_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      else
        w_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
  end

  assign w_prod_s = r_neg ? -w_acc_next : w_acc_next;
  assign w_q      = w_acc_next[WIDTH-1:0];
  assign w_r      = w_acc_next[2*WIDTH-1:WIDTH];

  always_comb begin
    w_calc_res = w_prod_s[WIDTH-1:0];
    case (r_f3)
      3'b001, 3'b010, 3'b011: w_calc_res = w_prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_calc_res = r_neg ? -w_q : w_q;
      3'b110, 3'b111:         w_calc_res = r_neg ? -w_r : w_r;
      default:                w_calc_res = w_prod_s[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_rd     <= '0;
      result_o <= '0;
      RDaddr_o <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_f3  <= w_f3;
            r_rd  <= RDaddr_i;
            r_neg <= w_neg_start;
            if (w_div0 | w_ovf) begin
              r_state  <= DONE;
              result_o <= w_special_res;
              RDaddr_o <= RDaddr_i;
            end else if (w_fast) begin
              r_state  <= DONE;
              result_o <= w_fast_res;
              RDaddr_o <= RDaddr_i;
            end else begin
              r_state <= CALC;
              r_count <= CW'(WIDTH);
              r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
              r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            r_state <= IDLE;
            r_count <= '0;
          end else begin
            r_acc   <= w_acc_next;
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
              r_state  <= DONE;
              result_o <= w_calc_res;
              RDaddr_o <= r_rd;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o  = (r_state != IDLE);
  assign done_o  = (r_state == DONE);
  assign stall_o = rst_i & (((r_state == IDLE) & w_start) | (r_state == CALC));

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Brief    : Directed self-checking bench for ex_muldiv_unit with a result queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
  localparam int MS = 0;
`else
  localparam int ML = 33;
  localparam int MS = 32;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, flush_i;
  logic [9:0]  func_i;
  logic [31:0] RS1data_i, RS2data_i;
  logic [4:0]  RDaddr_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  RDaddr_o;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .func_i(func_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .RDaddr_i(RDaddr_i),
    .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .RDaddr_o(RDaddr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] res; logic [4:0] rd; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  longint last_done_t = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference RV32M semantics using wide native arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, za, zb, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    ia = a;
    ib = b;
    case (f3)
      3'b000: begin p = za * zb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * zb; return p[63:32]; end
      3'b011: begin p = za * zb; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push, input logic exp_stall);
    exp_t e;
    valid_i   = 1'b1;
    func_i    = {7'b0000001, f3};
    RS1data_i = a;
    RS2data_i = b;
    RDaddr_i  = rd;
    if (push) begin
      e.res = model(f3, a, b);
      e.rd  = rd;
      sb.push_back(e);
    end
    #1;
    chk("start_stall", {31'd0, stall_o}, {31'd0, exp_stall});
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int exp_stall_cyc);
    int  lat = 0;
    int  st  = 0;
    bit  seen = 0;
    exp_t e;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1;
        lat  = i;
      end else if (stall_o) begin
        st++;
      end
    end
    valid_i = 1'b0;
    chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      last_done_t = $time;
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_stallcyc"}, st, exp_stall_cyc);
      chk({tag, "_done_stall"}, {31'd0, stall_o}, 32'd0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_res"}, result_o, e.res);
        chk({tag, "_rd"}, {27'd0, RDaddr_o}, {27'd0, e.rd});
      end else begin
        chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    longint t1;
    rst_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    func_i = '0; RS1data_i = '0; RS2data_i = '0; RDaddr_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", {27'd0, RDaddr_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    valid_i = 1'b1; func_i = {7'b0000001, 3'b000}; #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    valid_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;

    @(negedge clk_i); issue(3'b000, 32'd7, 32'd6, 5'd5, 1, 1'b1);
    wait_done("mul", ML, MS);
    @(negedge clk_i); issue(3'b001, 32'hFFFF_FFFF, 32'd2, 5'd6, 1, 1'b1);
    wait_done("mulh", ML, MS);
    @(negedge clk_i); issue(3'b011, 32'hFFFF_FFFF, 32'd2, 5'd7, 1, 1'b1);
    wait_done("mulhu", ML, MS);
    @(negedge clk_i); issue(3'b010, 32'hFFFF_FFFD, 32'hF000_0005, 5'd8, 1, 1'b1);
    wait_done("mulhsu", ML, MS);
    @(negedge clk_i); issue(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, 1, 1'b1);
    wait_done("mul_big", ML, MS);
    @(negedge clk_i); issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 1, 1'b1);
    wait_done("div", 33, 32);
    @(negedge clk_i); issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 1, 1'b1);
    wait_done("rem", 33, 32);
    @(negedge clk_i); issue(3'b101, 32'hFFFF_FFFF, 32'd7, 5'd12, 1, 1'b1);
    wait_done("divu", 33, 32);
    @(negedge clk_i); issue(3'b110, 32'd100, 32'hFFFF_FFFD, 5'd13, 1, 1'b1);
    wait_done("rem_negdiv", 33, 32);

    @(negedge clk_i); issue(3'b101, 32'd100, 32'd0, 5'd14, 1, 1'b1);
    wait_done("divu_by0", 1, 0);
    @(negedge clk_i); issue(3'b110, 32'd100, 32'd0, 5'd15, 1, 1'b1);
    wait_done("rem_by0", 1, 0);
    @(negedge clk_i); issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1, 1'b1);
    wait_done("rem_ovf", 1, 0);
    @(negedge clk_i); issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1, 1'b1);
    wait_done("div_ovf", 1, 0);

    // Non-M funct7 must not start
    @(negedge clk_i);
    valid_i = 1'b1; func_i = {7'b0100000, 3'b000}; #1;
    chk("nonm_stall", {31'd0, stall_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    chk("nonm_busy", {31'd0, busy_o}, 32'd0);
    valid_i = 1'b0;

    // Flush in IDLE blocks the start
    @(negedge clk_i);
    valid_i = 1'b1; func_i = {7'b0000001, 3'b000}; flush_i = 1'b1; #1;
    chk("idle_flush_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    chk("idle_flush_busy", {31'd0, busy_o}, 32'd0);
    valid_i = 1'b0; flush_i = 1'b0;

    // Flush mid-CALC
    @(negedge clk_i); issue(3'b101, 32'd1000, 32'd3, 5'd18, 0, 1'b1);
    repeat (10) @(negedge clk_i);
    chk("flush_pre_busy", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1; valid_i = 1'b0;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    chk("flush_result", result_o, 32'h8000_0000);
    n = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) n++;
    end
    chk("flush_no_done", n, 0);

    // Asynchronous reset mid-CALC, between clock edges
    @(negedge clk_i); issue(3'b101, 32'd5000, 32'd7, 5'd19, 0, 1'b1);
    repeat (5) @(negedge clk_i);
    #2; rst_i = 1'b0; #1;
    chk("arst_result", result_o, 32'd0);
    chk("arst_done", {31'd0, done_o}, 32'd0);
    chk("arst_rd", {27'd0, RDaddr_o}, 32'd0);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i); valid_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i); issue(3'b000, 32'd3, 32'd3, 5'd20, 1, 1'b1);
    wait_done("mul_after_rst", ML, MS);

    // Back-to-back: second op presented during the first op's DONE cycle
    @(negedge clk_i); issue(3'b111, 32'd17, 32'd5, 5'd21, 1, 1'b1);
    wait_done("remu_b2b", 33, 32);
    t1 = last_done_t;
    issue(3'b000, 32'd4, 32'd4, 5'd22, 1, 1'b0);
    wait_done("mul_b2b", ML + 1, MS + 1);
    chk("b2b_gap", 32'(last_done_t - t1), 32'((ML + 1) * 10));

    chk("sb_empty", sb.size(), 0);
    repeat (2) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Sits directly downstream of the ID/EX pipeline register and consumes its RS1/RS2 data, func and RD address outputs.
- Produces a 32-bit result and an RD tag for the EX/MEM stage.
- Raises a stall to freeze the PC, IF/ID and ID/EX registers while a multi-cycle operation is in flight.

Parameters:
- WIDTH, 32, operand/result width; the count register is $clog2(WIDTH)+1 bits.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- valid_i  input  1  ID/EX holds an M-extension instruction (funct7 = 0000001).
- func_i  input  10  {funct7, funct3} from ID/EX; funct3 selects the op.
- RS1data_i  input  WIDTH  operand A (dividend / multiplicand).
- RS2data_i  input  WIDTH  operand B (divisor / multiplier).
- RDaddr_i  input  5  destination register from ID/EX.
- flush_i  input  1  kill the in-flight op (branch/exception flush).
- stall_o  output  1  pipeline freeze request to the PC, IF/ID and ID/EX registers (drives cpu_stall).
- busy_o  output  1  FSM is not in IDLE.
- done_o  output  1  one-cycle pulse: result_o/RDaddr_o are valid.
- result_o  output  WIDTH  operation result.
- RDaddr_o  output  5  destination tag captured at start.

Behaviour:
- Reset (rst_i = 0, any time, including mid-op):
  - State goes to IDLE.
  - done_o = 0, result_o = 0, RDaddr_o = 0, busy_o = 0.
  - Internal accumulators and counter are cleared.
  - stall_o = 0 while reset is asserted.
- States: IDLE, CALC, DONE.
- IDLE:
  - On valid_i & ~flush_i, latch the operands, funct3 and RDaddr_i.
  - Special case, next state DONE, no CALC: divide by zero, result = all-ones for DIV/DIVU, RS1 for REM/REMU.
  - Special case, next state DONE, no CALC: signed overflow (DIV/REM with RS1 = 0x80000000, RS2 = 0xFFFFFFFF), result = 0x80000000 for DIV, 0 for REM.
  - Otherwise, next state CALC with count = WIDTH.
- CALC:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle on the operand magnitudes.
  - count decrements each cycle; at count = 1 the next state is DONE.
  - Total latency from start to done_o is WIDTH + 1 = 33 cycles.
- DONE:
  - done_o = 1 for exactly one cycle, and result_o is registered.
  - Next state is IDLE unconditionally.
  - result_o and RDaddr_o hold their values until the next DONE.
- funct3 selection:
  - 000 MUL: low WIDTH bits of the product.
  - 001 MULH: high bits, signed x signed.
  - 010 MULHSU: high bits, signed x unsigned.
  - 011 MULHU: high bits, unsigned x unsigned.
  - 100 DIV, 101 DIVU: quotient.
  - 110 REM, 111 REMU: remainder.
- Signed ops:
  - Operands are converted to magnitudes at start.
  - The product sign is the XOR of the operand signs.
  - The quotient sign is the XOR of the operand signs; the remainder takes the dividend's sign.
  - Sign is applied in two's complement on entering DONE; the product is 2*WIDTH bits internally.
- stall_o = (IDLE & valid_i & ~flush_i) | CALC.
  - stall_o is low in DONE, so ID/EX advances on the DONE edge and the next valid_i is sampled in the following IDLE cycle.
- flush_i:
  - In IDLE it blocks the start.
  - In CALC it forces IDLE on the next edge, with no done_o and result_o unchanged.
  - In DONE it has no effect; the result retires.
- Back-to-back M ops: the second starts in the first IDLE cycle after DONE, giving 34 cycles per op.
- func_i with funct7 ≠ 0000001 while valid_i = 1 is ignored; no start occurs.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle combinational 2*WIDTH multiplier.
  - Sequence is IDLE -> DONE, with done_o 1 cycle after start.
  - stall_o is high only during the start cycle.
  - Divides are unchanged.
- Undefined: all multiplies iterate through CALC (33-cycle latency); the unit contains no combinational multiplier.

Test Plan:
- MUL: RS1 = 7, RS2 = 6, RDaddr = 5 -> stall_o high for 33 cycles, done_o pulses at cycle 33, result_o = 42, RDaddr_o = 5. With MULDIV_FAST_MUL_EN, done_o instead pulses at cycle 1.
- Signed multiply/divide:
  - MULH with RS1 = 0xFFFFFFFF (-1), RS2 = 2 -> result_o = 0xFFFFFFFF.
  - MULHU with the same operands -> 0x00000001.
  - DIV with -7 / 2 -> 0xFFFFFFFD (-3).
  - REM with -7 / 2 -> 0xFFFFFFFF (-1).
- Special cases:
  - DIVU 100 / 0 -> done_o at cycle 1, result 0xFFFFFFFF.
  - REM 100 / 0 -> 100.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- Flush: start DIVU 1000 / 3, assert flush_i at cycle 10 -> IDLE next cycle, no done_o, stall_o drops, previous result_o retained.
- Async reset: assert rst_i = 0 mid-CALC between clock edges -> outputs 0 immediately, busy_o = 0. After release, a new MUL 3 x 3 returns 9.
- Back-to-back: REMU 17 % 5 followed by MUL 4 x 4 with valid_i held through the stall -> done_o pulses 34 cycles apart, results 2 then 16, RDaddr_o tags match each instruction.
